// File: rtl/regfile_arbiter_if.sv
// Bundle between the two register-file clients, the register file itself and
// the arbiter: request/grant handshakes, write/read ports and the read response.
interface regfile_arbiter_if #(
    parameter int AW   = 3,
    parameter int DW   = 8,
    parameter int NREG = 8
);
    logic            a_req;
    logic            a_we;
    logic [AW-1:0]   a_addr;
    logic [DW-1:0]   a_wdata;
    logic            a_gnt;

    logic            b_req;
    logic            b_we;
    logic [AW-1:0]   b_addr;
    logic [DW-1:0]   b_wdata;
    logic            b_gnt;

    logic [NREG-1:0] rf_we;
    logic [DW-1:0]   rf_wdata;
    logic [AW-1:0]   rf_raddr;
    logic [DW-1:0]   rf_rdata;

    logic            rd_valid;
    logic            rd_owner;
    logic [DW-1:0]   rd_data;

    // Client and register-file side.
    modport master (
        output a_req, a_we, a_addr, a_wdata,
        output b_req, b_we, b_addr, b_wdata,
        output rf_rdata,
        input  a_gnt, b_gnt, rf_we, rf_wdata, rf_raddr,
        input  rd_valid, rd_owner, rd_data
    );

    // Arbiter side.
    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        input  b_req, b_we, b_addr, b_wdata,
        input  rf_rdata,
        output a_gnt, b_gnt, rf_we, rf_wdata, rf_raddr,
        output rd_valid, rd_owner, rd_data
    );
endinterface

// File: rtl/regfile_arbiter.sv
// Two-client round-robin access controller for an NREG x DW register file:
// one access per cycle, writes go straight to the enables, reads return next cycle.
module regfile_arbiter #(
    parameter int AW   = 3,
    parameter int DW   = 8,
    parameter int NREG = 8
) (
    input  logic               clk,
    input  logic               reset,
    regfile_arbiter_if.slave   bus
);
    logic          last_gnt_reg, last_gnt_next;
    logic          rd_valid_reg, rd_valid_next;
    logic          rd_owner_reg, rd_owner_next;
    logic [DW-1:0] rd_data_reg,  rd_data_next;

    logic          pick_b;
    logic          a_gnt_c, b_gnt_c, any_gnt;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;
    logic          wr_gnt, rd_gnt;

    // B wins only if A is idle or A was the previous winner.
    always_comb begin
        pick_b    = bus.b_req && (!bus.a_req || !last_gnt_reg);
        a_gnt_c   = !reset && bus.a_req && !pick_b;
        b_gnt_c   = !reset && pick_b;
        any_gnt   = a_gnt_c || b_gnt_c;
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        // Only the granted client's fields are looked at, so junk on an idle client stays out.
        if (a_gnt_c) begin
            sel_we    = bus.a_we;
            sel_addr  = bus.a_addr;
            sel_wdata = bus.a_wdata;
        end else if (b_gnt_c) begin
            sel_we    = bus.b_we;
            sel_addr  = bus.b_addr;
            sel_wdata = bus.b_wdata;
        end
        wr_gnt = any_gnt && sel_we;
        rd_gnt = any_gnt && !sel_we;
    end

    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_we
            assign bus.rf_we[gi] = wr_gnt && (sel_addr == AW'(gi));
        end
    endgenerate

    assign bus.rf_wdata = wr_gnt ? sel_wdata : '0;
    assign bus.rf_raddr = rd_gnt ? sel_addr  : '0;
    assign bus.a_gnt    = a_gnt_c;
    assign bus.b_gnt    = b_gnt_c;

    always_comb begin
        last_gnt_next = last_gnt_reg;
        rd_valid_next = rd_gnt;
        rd_owner_next = rd_owner_reg;
        rd_data_next  = rd_data_reg;
        if (any_gnt) begin
            last_gnt_next = b_gnt_c;
        end
        if (rd_gnt) begin
            rd_owner_next = b_gnt_c;
            rd_data_next  = bus.rf_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_gnt_reg <= 1'b1;
            rd_valid_reg <= 1'b0;
            rd_owner_reg <= 1'b0;
            rd_data_reg  <= '0;
        end else begin
            last_gnt_reg <= last_gnt_next;
            rd_valid_reg <= rd_valid_next;
            rd_owner_reg <= rd_owner_next;
            rd_data_reg  <= rd_data_next;
        end
    end

    assign bus.rd_valid = rd_valid_reg;
    assign bus.rd_owner = rd_owner_reg;
    assign bus.rd_data  = rd_data_reg;
endmodule

// File: tb/tb_regfile_arbiter.sv
// Scoreboard bench for regfile_arbiter: a behavioural client/register model predicts
// grants and write strobes each cycle and queues read responses for a separate monitor.
module tb_regfile_arbiter;
    localparam int AW   = 3;
    localparam int DW   = 8;
    localparam int NREG = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    regfile_arbiter_if #(.AW(AW), .DW(DW), .NREG(NREG)) bus ();

    regfile_arbiter #(.AW(AW), .DW(DW), .NREG(NREG)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Register file the arbiter drives: enable-gated flops plus a read mux.
    logic [DW-1:0] rf_mem [NREG];
    always @(posedge clk) begin
        for (int i = 0; i < NREG; i++)
            if (bus.rf_we[i]) rf_mem[i] <= bus.rf_wdata;
    end
    assign bus.rf_rdata = rf_mem[bus.rf_raddr];

    typedef struct {
        logic          owner;
        logic [DW-1:0] data;
    } rsp_t;

    rsp_t          exp_q [$];
    int            tests = 0;
    int            fails = 0;
    int            cyc   = 0;

    // Reference state: what each client is asking for, who won last, register contents.
    logic          pend  [2];
    logic          cwe   [2];
    logic [AW-1:0] caddr [2];
    logic [DW-1:0] cwd   [2];
    logic          model_last;
    logic [DW-1:0] model_mem [NREG];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic issue(input int c, input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        pend[c]  = 1'b1;
        cwe[c]   = we;
        caddr[c] = addr;
        cwd[c]   = wd;
    endtask

    // One clock cycle: drive requests, then check combinational outputs against the model.
    task automatic cycle(input logic rst, output logic [1:0] g);
        logic          exp_a, exp_b, w_we;
        int            w;
        logic [AW-1:0] w_addr;
        logic [DW-1:0] w_wd;
        logic [NREG-1:0] exp_we;
        @(posedge clk);
        #1;
        reset       = rst;
        bus.a_req   = pend[0];
        bus.a_we    = pend[0] ? cwe[0]   : 1'($urandom);
        bus.a_addr  = pend[0] ? caddr[0] : AW'($urandom);
        bus.a_wdata = pend[0] ? cwd[0]   : DW'($urandom);
        bus.b_req   = pend[1];
        bus.b_we    = pend[1] ? cwe[1]   : 1'($urandom);
        bus.b_addr  = pend[1] ? caddr[1] : AW'($urandom);
        bus.b_wdata = pend[1] ? cwd[1]   : DW'($urandom);
        @(negedge clk);
        cyc++;
        exp_a = !rst && pend[0] && (!pend[1] || model_last);
        exp_b = !rst && pend[1] && !exp_a;
        g = {bus.b_gnt, bus.a_gnt};
        chk("grant", {bus.b_gnt, bus.a_gnt}, {exp_b, exp_a});
        w      = exp_b ? 1 : 0;
        w_we   = cwe[w];
        w_addr = caddr[w];
        w_wd   = cwd[w];
        exp_we = '0;
        if ((exp_a || exp_b) && w_we) exp_we[w_addr] = 1'b1;
        chk("rf_we", bus.rf_we, exp_we);
        chk("rf_wdata", bus.rf_wdata, ((exp_a || exp_b) && w_we) ? w_wd : '0);
        chk("rf_raddr", bus.rf_raddr, ((exp_a || exp_b) && !w_we) ? w_addr : '0);
        if (exp_a || exp_b) begin
            $display("[TB] cyc %0d: client %s %s addr=%0d data=%02h", cyc,
                     exp_b ? "B" : "A", w_we ? "write" : "read", w_addr,
                     w_we ? w_wd : model_mem[w_addr]);
            if (w_we) model_mem[w_addr] = w_wd;
            else      exp_q.push_back('{owner: exp_b, data: model_mem[w_addr]});
            model_last = exp_b;
            pend[w]    = 1'b0;
        end
        if (rst) model_last = 1'b1;
    endtask

    task automatic drain();
        logic [1:0] g;
        int n = 0;
        while ((pend[0] || pend[1]) && n < 50) begin
            cycle(1'b0, g);
            n++;
        end
        chk("drain_pending", {pend[0], pend[1]}, 2'b00);
    endtask

    // Monitor: every rd_valid must match the oldest queued response, and vice versa.
    initial begin
        rsp_t r;
        logic exp_v;
        forever begin
            @(posedge clk);
            #3;
            exp_v = (exp_q.size() != 0);
            chk("rd_valid", bus.rd_valid, exp_v);
            if (exp_v) begin
                r = exp_q.pop_front();
                if (bus.rd_valid) begin
                    chk("rd_owner", bus.rd_owner, r.owner);
                    chk("rd_data", bus.rd_data, r.data);
                end
            end
        end
    end

    initial begin
        logic [1:0] g;
        logic [5:0] seq;
        for (int i = 0; i < 2; i++) pend[i] = 1'b0;
        for (int i = 0; i < NREG; i++) begin
            model_mem[i] = '0;
            cwe[i % 2]   = 1'b0;
        end
        model_last = 1'b1;
        bus.a_req = 1'b0; bus.a_we = 1'b0; bus.a_addr = '0; bus.a_wdata = '0;
        bus.b_req = 1'b0; bus.b_we = 1'b0; bus.b_addr = '0; bus.b_wdata = '0;

        // Both clients request while reset is held; nothing may be granted.
        issue(0, 1'b1, 3'd1, 8'h11);
        issue(1, 1'b1, 3'd2, 8'h22);
        cycle(1'b1, g);
        cycle(1'b1, g);
        chk("reset_rd_valid", bus.rd_valid, 1'b0);
        chk("reset_rd_owner", bus.rd_owner, 1'b0);
        chk("reset_rd_data", bus.rd_data, 8'h00);
        cycle(1'b0, g);
        chk("first_after_reset_is_a", g, 2'b01);
        drain();

        // A writes A5 to reg 3, B reads it back.
        issue(0, 1'b1, 3'd3, 8'hA5);
        cycle(1'b0, g);
        chk("wr_a5_rf_we", bus.rf_we, 8'b0000_1000);
        issue(1, 1'b0, 3'd3, 8'h00);
        drain();
        cycle(1'b0, g);

        // Write then immediate read of the same register.
        issue(0, 1'b1, 3'd7, 8'h3C);
        cycle(1'b0, g);
        issue(0, 1'b0, 3'd7, 8'h00);
        cycle(1'b0, g);
        cycle(1'b0, g);
        cycle(1'b0, g);
        chk("rd_valid_dropped", bus.rd_valid, 1'b0);
        chk("rd_data_held", bus.rd_data, 8'h3C);

        // Continuous contention right after reset alternates A, B, A, ...
        cycle(1'b1, g);
        seq = '0;
        for (int i = 0; i < 6; i++) begin
            if (!pend[0]) issue(0, 1'b1, 3'd1, DW'($urandom));
            if (!pend[1]) issue(1, 1'b1, 3'd2, DW'($urandom));
            cycle(1'b0, g);
            seq[i] = g[1];
        end
        chk("alternation", seq, 6'b101010);
        drain();

        // Address sweep: write i*17 everywhere, then read all back.
        for (int i = 0; i < NREG; i++) begin
            issue(i % 2, 1'b1, AW'(i), DW'(i * 17));
            drain();
        end
        for (int i = 0; i < NREG; i++) begin
            issue((i + 1) % 2, 1'b0, AW'(i), 8'h00);
            drain();
        end
        cycle(1'b0, g);

        // Read granted right before reset: response shows once, then reset wipes it.
        issue(0, 1'b0, 3'd5, 8'h00);
        cycle(1'b0, g);
        cycle(1'b1, g);
        @(posedge clk);
        #2;
        chk("rd_valid_after_reset", bus.rd_valid, 1'b0);
        chk("rd_data_after_reset", bus.rd_data, 8'h00);

        // Randomised traffic with occasional resets.
        for (int i = 0; i < 200; i++) begin
            for (int c = 0; c < 2; c++)
                if (!pend[c] && $urandom_range(0, 2) != 0)
                    issue(c, 1'($urandom), AW'($urandom), DW'($urandom));
            cycle($urandom_range(0, 49) == 0, g);
        end
        drain();
        cycle(1'b0, g);
        cycle(1'b0, g);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
